// File: rtl/spi_master.sv
// Single-byte SPI master: CS/SCLK/MOSI driver with MISO capture, SCLK = CLK / (2*CLK_DIV).
// Optional macro SPI_MASTER_LSB_FIRST_EN selects LSB-first bit order (default MSB-first).
module spi_master #(
  parameter logic [1:0] MODE    = 2'd3,
  parameter int         CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       MISO,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx
);

  localparam logic CPOL = MODE[1];
  localparam logic CPHA = MODE[0];
  localparam int   CW   = $clog2(CLK_DIV);

  if (CLK_DIV < 4) begin : g_div_chk
    $error("spi_master: CLK_DIV must be >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

`ifdef SPI_MASTER_LSB_FIRST_EN
  function automatic logic tx_bit(input logic [7:0] v);
    return v[0];
  endfunction
  function automatic logic [7:0] tx_shift(input logic [7:0] v);
    return {1'b0, v[7:1]};
  endfunction
  function automatic logic [7:0] rx_shift(input logic [7:0] v,
                                          input logic b);
    return {b, v[7:1]};
  endfunction
`else
  function automatic logic tx_bit(input logic [7:0] v);
    return v[7];
  endfunction
  function automatic logic [7:0] tx_shift(input logic [7:0] v);
    return {v[6:0], 1'b0};
  endfunction
  function automatic logic [7:0] rx_shift(input logic [7:0] v,
                                          input logic b);
    return {v[6:0], b};
  endfunction
`endif

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] div_cnt;
  logic [4:0]    edge_cnt;
  logic [4:0]    edge_nxt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          tick;
  logic          accept;
  logic          edge_en;
  logic          lead;
  logic          sample;
  logic          drive;
  logic          finish;

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = SETUP;
      SETUP: if (tick) state_nxt = SHIFT;
      SHIFT: if (tick && edge_cnt == 5'd15) state_nxt = HOLD;
      HOLD:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // start in the done cycle is dropped; back-to-back starts one cycle later
  always_comb begin
    tick     = (div_cnt == CW'(CLK_DIV - 1));
    accept   = (state == IDLE) && start && !done;
    edge_en  = tick && (state == SETUP || state == SHIFT);
    edge_nxt = edge_cnt + 5'd1;
    lead     = edge_nxt[0];
    sample   = edge_en && (lead ^ CPHA);
    drive    = edge_en && (CPHA ? lead
                                : (!lead && edge_nxt != 5'd16));
    finish   = (state == HOLD) && tick;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx       <= '0;
      SCLK     <= CPOL;
      MOSI     <= 1'b0;
      CS       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + CW'(1);
      if (accept) begin
        CS       <= 1'b0;
        busy     <= 1'b1;
        edge_cnt <= '0;
        if (CPHA) begin
          tx_sr <= data_in;
        end else begin
          MOSI  <= tx_bit(data_in);
          tx_sr <= tx_shift(data_in);
        end
      end
      if (edge_en) begin
        SCLK     <= ~SCLK;
        edge_cnt <= edge_nxt;
      end
      if (drive) begin
        MOSI  <= tx_bit(tx_sr);
        tx_sr <= tx_shift(tx_sr);
      end
      if (sample) rx_sr <= rx_shift(rx_sr, MISO);
      if (finish) begin
        CS       <= 1'b1;
        busy     <= 1'b0;
        done     <= 1'b1;
        rx       <= rx_sr;
        MOSI     <= 1'b0;
        edge_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one DUT per MODE, each looped to a
// behavioural slave that shifts on SCLK edges seen on its own CLK.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;

  logic       start_v [4];
  logic       cs_v    [4];
  logic       sclk_v  [4];
  logic       mosi_v  [4];
  logic       miso_v  [4];
  logic       busy_v  [4];
  logic       done_v  [4];
  logic [7:0] rx_v    [4];
  logic [7:0] srx_v   [4];
  logic [7:0] stx     [4];

  logic       cs_h   [160];
  logic       sclk_h [160];
  logic       mosi_h [160];
  logic       busy_h [160];
  logic       done_h [160];
  logic [7:0] rx_h   [160];
  logic [7:0] srx_h  [160];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam logic CPHA_G = (g % 2) == 1;
    logic [4:0] sedg   = '0;
    logic       sclk_q = 1'b0;
    logic       cs_q   = 1'b1;
    logic [7:0] srx    = '0;
    logic [4:0] e;
    logic [2:0] idx;
    int         t;

    spi_master #(.MODE(2'(g)), .CLK_DIV(4)) u_dut (
      .CLK    (clk),
      .reset  (reset),
      .start  (start_v[g]),
      .data_in(din),
      .MISO   (miso_v[g]),
      .SCLK   (sclk_v[g]),
      .MOSI   (mosi_v[g]),
      .CS     (cs_v[g]),
      .busy   (busy_v[g]),
      .done   (done_v[g]),
      .rx     (rx_v[g])
    );

    assign e = sedg + 5'd1;

    always_comb begin
      t = 0;
      if (CPHA_G) t = (sedg == 5'd0) ? 0 : (int'(sedg) - 1) / 2;
      else        t = int'(sedg) / 2;
      if (t > 7) t = 7;
      idx = 3'(t);
    end

    always @(posedge clk) begin
      sclk_q <= sclk_v[g];
      cs_q   <= cs_v[g];
      if (!cs_v[g] && cs_q) begin
        sedg <= '0;
      end else if (!cs_v[g] && sclk_v[g] != sclk_q) begin
        sedg <= e;
`ifdef SPI_MASTER_LSB_FIRST_EN
        if (e[0] ^ CPHA_G) srx <= {mosi_v[g], srx[7:1]};
`else
        if (e[0] ^ CPHA_G) srx <= {srx[6:0], mosi_v[g]};
`endif
      end
    end

    assign srx_v[g] = srx;
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign miso_v[g] = stx[g][idx];
`else
    assign miso_v[g] = stx[g][3'd7 - idx];
`endif
  end

  // cycle c of the trace = the cycle whose inputs are sampled at posedge c
  task automatic capture(input int m, input logic [7:0] tx, input int n,
                         input int p1, input int p2, input int p3,
                         input int rst_at);
    for (int c = 0; c <= n; c++) begin
      start_v[m] = (c == 0) || (c == p1) || (c == p2) || (c == p3);
      din        = (c == 0) ? tx : ~tx;
      reset      = (c == rst_at);
      cs_h[c]    = cs_v[m];
      sclk_h[c]  = sclk_v[m];
      mosi_h[c]  = mosi_v[m];
      busy_h[c]  = busy_v[m];
      done_h[c]  = done_v[m];
      rx_h[c]    = rx_v[m];
      srx_h[c]   = srx_v[m];
      @(negedge clk);
    end
    start_v[m] = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic test_reset();
    for (int m = 0; m < 4; m++) begin
      logic cpol;
      cpol = (m >= 2);
      n_checks += 6;
      if (cs_v[m] !== 1'b1) $display("FAIL rst_cs m%0d: got %b want 1", m, cs_v[m]);
      else n_pass++;
      if (sclk_v[m] !== cpol) $display("FAIL rst_sclk m%0d: got %b want %b", m, sclk_v[m], cpol);
      else n_pass++;
      if (mosi_v[m] !== 1'b0) $display("FAIL rst_mosi m%0d: got %b want 0", m, mosi_v[m]);
      else n_pass++;
      if (busy_v[m] !== 1'b0) $display("FAIL rst_busy m%0d: got %b want 0", m, busy_v[m]);
      else n_pass++;
      if (done_v[m] !== 1'b0) $display("FAIL rst_done m%0d: got %b want 0", m, done_v[m]);
      else n_pass++;
      if (rx_v[m] !== 8'h00) $display("FAIL rst_rx m%0d: got %h want 00", m, rx_v[m]);
      else n_pass++;
    end
  endtask

  task automatic test_loopback();
    int lows;
    int dones;
    stx[3] = 8'h3C;
    capture(3, 8'hA5, 75, -1, -1, -1, -1);
    lows  = 0;
    dones = 0;
    for (int c = 1; c <= 68; c++) if (cs_h[c] === 1'b0) lows++;
    for (int c = 0; c <= 75; c++) if (done_h[c] === 1'b1) dones++;
    n_checks += 14;
    if (cs_h[0] !== 1'b1) $display("FAIL lb_cs0: got %b want 1", cs_h[0]);
    else n_pass++;
    if (lows != 68) $display("FAIL lb_cs_low: got %0d want 68", lows);
    else n_pass++;
    if (cs_h[69] !== 1'b1) $display("FAIL lb_cs69: got %b want 1", cs_h[69]);
    else n_pass++;
    if (busy_h[1] !== 1'b1) $display("FAIL lb_busy1: got %b want 1", busy_h[1]);
    else n_pass++;
    if (busy_h[69] !== 1'b0) $display("FAIL lb_busy69: got %b want 0", busy_h[69]);
    else n_pass++;
    if (done_h[69] !== 1'b1) $display("FAIL lb_done69: got %b want 1", done_h[69]);
    else n_pass++;
    if (dones != 1) $display("FAIL lb_done_cnt: got %0d want 1", dones);
    else n_pass++;
    if (rx_h[69] !== 8'h3C) $display("FAIL lb_rx: got %h want 3c", rx_h[69]);
    else n_pass++;
    if (rx_h[68] !== 8'h00) $display("FAIL lb_rx_hold: got %h want 00", rx_h[68]);
    else n_pass++;
    if (srx_h[69] !== 8'hA5) $display("FAIL lb_slave_rx: got %h want a5", srx_h[69]);
    else n_pass++;
    if (sclk_h[4] !== 1'b1 || sclk_h[5] !== 1'b0)
      $display("FAIL lb_edge1: got %b%b want 10", sclk_h[4], sclk_h[5]);
    else n_pass++;
    if (sclk_h[64] !== 1'b0 || sclk_h[65] !== 1'b1)
      $display("FAIL lb_edge16: got %b%b want 01", sclk_h[64], sclk_h[65]);
    else n_pass++;
    if (mosi_h[68] !== 1'b1) $display("FAIL lb_mosi_last: got %b want 1", mosi_h[68]);
    else n_pass++;
    if (mosi_h[69] !== 1'b0) $display("FAIL lb_mosi_idle: got %b want 0", mosi_h[69]);
    else n_pass++;
  endtask

  task automatic test_modes();
    logic first;
`ifdef SPI_MASTER_LSB_FIRST_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    for (int m = 0; m < 4; m++) begin
      int   tog;
      logic cpol;
      cpol   = (m >= 2);
      stx[m] = 8'h69;
      capture(m, 8'h96, 75, -1, -1, -1, -1);
      tog = 0;
      for (int c = 1; c <= 75; c++) if (sclk_h[c] !== sclk_h[c-1]) tog++;
      n_checks += 5;
      if (rx_h[69] !== 8'h69) $display("FAIL mode%0d_rx: got %h want 69", m, rx_h[69]);
      else n_pass++;
      if (srx_h[69] !== 8'h96) $display("FAIL mode%0d_slave_rx: got %h want 96", m, srx_h[69]);
      else n_pass++;
      if (sclk_h[0] !== cpol) $display("FAIL mode%0d_idle_pre: got %b want %b", m, sclk_h[0], cpol);
      else n_pass++;
      if (sclk_h[75] !== cpol) $display("FAIL mode%0d_idle_post: got %b want %b", m, sclk_h[75], cpol);
      else n_pass++;
      if (tog != 16) $display("FAIL mode%0d_edges: got %0d want 16", m, tog);
      else n_pass++;
      if (m == 0) begin
        n_checks++;
        if (mosi_h[1] !== first) $display("FAIL mode0_mosi_first: got %b want %b", mosi_h[1], first);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int falls;
    stx[3] = 8'h81;
    capture(3, 8'h5A, 150, 20, 69, 70, -1);
    falls = 0;
    for (int c = 1; c <= 70; c++) if (cs_h[c-1] === 1'b1 && cs_h[c] === 1'b0) falls++;
    n_checks += 9;
    if (falls != 1) $display("FAIL b2b_cs_falls: got %0d want 1", falls);
    else n_pass++;
    if (done_h[69] !== 1'b1) $display("FAIL b2b_done1: got %b want 1", done_h[69]);
    else n_pass++;
    if (srx_h[69] !== 8'h5A) $display("FAIL b2b_din_hold: got %h want 5a", srx_h[69]);
    else n_pass++;
    if (rx_h[69] !== 8'h81) $display("FAIL b2b_rx1: got %h want 81", rx_h[69]);
    else n_pass++;
    if (cs_h[70] !== 1'b1) $display("FAIL b2b_cs70: got %b want 1", cs_h[70]);
    else n_pass++;
    if (busy_h[70] !== 1'b0) $display("FAIL b2b_busy70: got %b want 0", busy_h[70]);
    else n_pass++;
    if (cs_h[71] !== 1'b0) $display("FAIL b2b_cs71: got %b want 0", cs_h[71]);
    else n_pass++;
    if (done_h[139] !== 1'b1) $display("FAIL b2b_done2: got %b want 1", done_h[139]);
    else n_pass++;
    if (srx_h[139] !== 8'hA5) $display("FAIL b2b_slave_rx2: got %h want a5", srx_h[139]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    stx[3] = 8'h3C;
    capture(3, 8'h5A, 80, -1, -1, -1, 30);
    dones = 0;
    for (int c = 0; c <= 80; c++) if (done_h[c] === 1'b1) dones++;
    n_checks += 7;
    if (cs_h[30] !== 1'b0) $display("FAIL rm_cs30: got %b want 0", cs_h[30]);
    else n_pass++;
    if (cs_h[31] !== 1'b1) $display("FAIL rm_cs31: got %b want 1", cs_h[31]);
    else n_pass++;
    if (sclk_h[31] !== 1'b1) $display("FAIL rm_sclk31: got %b want 1", sclk_h[31]);
    else n_pass++;
    if (busy_h[31] !== 1'b0) $display("FAIL rm_busy31: got %b want 0", busy_h[31]);
    else n_pass++;
    if (rx_h[31] !== 8'h00) $display("FAIL rm_rx31: got %h want 00", rx_h[31]);
    else n_pass++;
    if (mosi_h[31] !== 1'b0) $display("FAIL rm_mosi31: got %b want 0", mosi_h[31]);
    else n_pass++;
    if (dones != 0) $display("FAIL rm_no_done: got %0d want 0", dones);
    else n_pass++;
    stx[3] = 8'hC3;
    capture(3, 8'hFF, 75, -1, -1, -1, -1);
    n_checks += 3;
    if (done_h[69] !== 1'b1) $display("FAIL rm_after_done: got %b want 1", done_h[69]);
    else n_pass++;
    if (rx_h[69] !== 8'hC3) $display("FAIL rm_after_rx: got %h want c3", rx_h[69]);
    else n_pass++;
    if (srx_h[69] !== 8'hFF) $display("FAIL rm_after_slave_rx: got %h want ff", srx_h[69]);
    else n_pass++;
  endtask

  task automatic test_bit_order();
    logic [7:0] tx;
`ifdef SPI_MASTER_LSB_FIRST_EN
    tx = 8'h01;
`else
    tx = 8'h80;
`endif
    stx[3] = tx;
    capture(3, tx, 75, -1, -1, -1, -1);
    n_checks += 5;
    if (mosi_h[5] !== 1'b1) $display("FAIL bo_mosi_first: got %b want 1", mosi_h[5]);
    else n_pass++;
    if (mosi_h[12] !== 1'b1) $display("FAIL bo_mosi_hold: got %b want 1", mosi_h[12]);
    else n_pass++;
    if (mosi_h[13] !== 1'b0) $display("FAIL bo_mosi_second: got %b want 0", mosi_h[13]);
    else n_pass++;
    if (rx_h[69] !== tx) $display("FAIL bo_rx: got %h want %h", rx_h[69], tx);
    else n_pass++;
    if (srx_h[69] !== tx) $display("FAIL bo_slave_rx: got %h want %h", srx_h[69], tx);
    else n_pass++;
  endtask

  initial begin
    for (int m = 0; m < 4; m++) begin
      start_v[m] = 1'b0;
      stx[m]     = 8'h00;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_loopback();
    test_modes();
    test_back_to_back();
    test_reset_mid();
    test_bit_order();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
